pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It is the next generation of the fixed 12-bit combinational RCA used in the CPU datapath.
- The operand width is split into STAGES equal chunks. Each chunk is added in its own pipeline stage, and the carry is registered between stages, so the ripple path per cycle is WIDTH/STAGES bits.
- Valid/ready handshakes on input and output.
- Produces result plus carry, signed-overflow and zero flags. Serves the ALU/address-generation path.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be an integer multiple of STAGES.
- STAGES, 4: number of pipeline stages (chunks), 1..WIDTH. Equals the latency in cycles.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- r  output  WIDTH  result
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  r == 0

Behaviour:
- Reset: one clock and one reset, clk and rst. rst is synchronous and active-high.
  - On rst, every stage valid bit is cleared, so out_valid=0.
  - r, cout, ovf and zero are forced to 0.
  - Operand/skew registers may hold any value.
- Effective operands: b_eff = sub ? ~b : b; c_eff = sub ? 1 : cin. Both are computed at the input.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff with the carry registered by stage k-1; stage 0 uses c_eff.
  - Registers the chunk sum and the carry out.
  - Upper, not-yet-added chunks are carried forward in skew registers.
  - Lower, finished sum chunks are carried forward in deskew registers.
- Global stall rule:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance=1, all stages shift one place. Stage 0 loads {in_valid, operands}.
  - When advance=0, every register holds.
- Bubbles (in_valid=0 when accepted) flow through as invalid stages. Throughput is 1 beat/cycle when out_ready is held high.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+STAGES, when no stall occurs. Each stall cycle adds 1.
- Outputs are registered at the final stage and held stable while out_valid=1 and out_ready=0.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = (a[MSB] == b_eff[MSB]) & (r[MSB] != a[MSB]), computed on the raw sum.
  - zero = ~|r.
- Wrap-around: results are modulo 2^WIDTH unless saturated (see Optional Feature).
- No reordering; beats leave in acceptance order.
- Reset mid-operation: all in-flight beats are discarded, never output. The first beat accepted after rst deasserts emerges STAGES cycles later.
- Simultaneous out_ready=1 and in_valid=1 with the pipeline full: the output beat leaves and the new beat enters in the same cycle, with no bubble.
- STAGES=1: a single-cycle registered adder with the same handshake.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the operands and piped alongside them.
  - For a beat with sat=1 and ovf=1, r is clamped: 0 followed by all 1s (max positive) if a[MSB]=0, else 1 followed by all 0s (min negative).
  - ovf still reports 1; zero is computed on the clamped r; cout is unaffected.
  - Beats with sat=0 wrap as normal.
- Undefined:
  - No sat port and no clamp logic; results always wrap.

Test Plan:
- WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> 4 cycles later r=0x00000000, cout=1, ovf=0, zero=1.
- a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> r=0x80000000, cout=0, ovf=1, zero=0.
- a=5, b=7, sub=1, cin=1 (ignored) -> r=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 -> r=2, cout=1.
- Stream 8 beats a=i, b=i<<16 (i=0..7) with out_ready low for cycles 5-7:
  - in_ready drops during the stall.
  - All 8 results arrive in order, r=i|(i<<16), none lost or duplicated.
  - Outputs stay stable while stalled.
- Load 3 beats, assert rst for 1 cycle in cycle 2 -> out_valid stays 0. The next accepted beat a=1, b=1 yields r=2 exactly 4 cycles after acceptance.
- ADDSUB_SAT_EN: a=0x7FFFFFFF, b=1, sat=1 -> r=0x7FFFFFFF, ovf=1. a=0x80000000, b=1, sub=1, sat=1 -> r=0x80000000, ovf=1. The same beats with sat=0 wrap.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// Optional macro ADDSUB_SAT_EN adds the per-beat 'sat' (saturate) request.
interface pipelined_addsub_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
`ifdef ADDSUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             cout;
    logic             ovf;
    logic             zero;

`ifdef ADDSUB_SAT_EN
    modport master (
        output in_valid, a, b, cin, sub, sat, out_ready,
        input  in_ready, out_valid, r, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, sat, out_ready,
        output in_ready, out_valid, r, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, r, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, r, cout, ovf, zero
    );
`endif
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH split into STAGES chunks,
// one chunk added per stage with the carry registered between stages.
// Optional macro ADDSUB_SAT_EN enables per-beat signed saturation.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_addsub_if.slave  bus
);
    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registers: a/b skew words, partial-sum deskew word, carry, valid
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] cin_d;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_d;
    logic              ovf_d;
    logic              zero_d;
    logic [CW:0]       chunk;
`ifdef ADDSUB_SAT_EN
    logic [STAGES-1:0] sat_q;
    logic [STAGES-1:0] sat_d;
`endif

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign advance = !v_q[LAST] || bus.out_ready;
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign c_eff   = bus.sub ? 1'b1 : bus.cin;

    // Next value of every stage: shift in, add this stage's chunk, form final flags
    always_comb begin
        a_d[0]   = bus.a;
        b_d[0]   = b_eff;
        cin_d[0] = c_eff;
        s_d[0]   = '0;
        v_d[0]   = bus.in_valid;
`ifdef ADDSUB_SAT_EN
        sat_d[0] = bus.sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            cin_d[k] = c_q[k-1];
            s_d[k]   = s_q[k-1];
            v_d[k]   = v_q[k-1];
`ifdef ADDSUB_SAT_EN
            sat_d[k] = sat_q[k-1];
`endif
        end
        chunk = '0;
        c_d   = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, a_d[k][k*CW +: CW]} + {1'b0, b_d[k][k*CW +: CW]}
                  + (CW+1)'(cin_d[k]);
            s_d[k][k*CW +: CW] = chunk[CW-1:0];
            c_d[k]             = chunk[CW];
        end
        ovf_d = (a_d[LAST][MSB] == b_d[LAST][MSB]) && (s_d[LAST][MSB] != a_d[LAST][MSB]);
`ifdef ADDSUB_SAT_EN
        if (sat_d[LAST] && ovf_d) begin
            s_d[LAST] = a_d[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d = ~|s_d[LAST];
    end

    // Pipeline registers: clear on reset, shift on advance, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
`ifdef ADDSUB_SAT_EN
            sat_q  <= '0;
`endif
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
`ifdef ADDSUB_SAT_EN
            sat_q  <= sat_d;
`endif
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.r         = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4).
module tb_pipelined_addsub;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    typedef struct packed {
        logic [31:0] r;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
`ifdef ADDSUB_SAT_EN
    logic sat_sel = 1'b0;
`endif

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o, input logic z);
        exp_t e;
        e.r = r; e.cout = c; e.ovf = o; e.zero = z;
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Present one beat and push its expected result once the DUT will accept it
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input exp_t e);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
`ifdef ADDSUB_SAT_EN
        bus.sat = sat_sel;
`endif
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                return;
            end
        end
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready low 100 cycles, expected high");
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    endtask

    // Monitor: pop and compare every transferred beat; check hold while stalled
    initial begin
        logic        stalled;
        logic [31:0] held;
        exp_t        e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check1("hold_valid", bus.out_valid, 1'b1);
                    check32("hold_r", bus.r, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got r=%h expected no beat", bus.r);
                    end else begin
                        e = sb.pop_front();
                        check32("r", bus.r, e.r);
                        check1("cout", bus.cout, e.cout);
                        check1("ovf", bus.ovf, e.ovf);
                        check1("zero", bus.zero, e.zero);
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held = bus.r;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
        bus.sat = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check32("rst_r", bus.r, 32'h0);
        check1("rst_cout", bus.cout, 1'b0);
        check1("rst_ovf", bus.ovf, 1'b0);
        check1("rst_zero", bus.zero, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("idle_in_ready", bus.in_ready, 1'b1);

        // Directed add/sub vectors, back to back
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0));
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        send(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1, 1'b1));
        send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, mk(32'h0100_0100, 1'b0, 1'b0, 1'b0));
        send(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0));
        idle();
        drain();

        // Streaming with a 3-cycle output stall
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.out_ready = !(c >= 5 && c <= 7);
            if (idx < 8) begin
                bus.in_valid = 1'b1;
                bus.a = 32'(idx);
                bus.b = 32'(idx) << 16;
                bus.cin = 1'b0;
                bus.sub = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 5 && c <= 7) check1("stall_in_ready", bus.in_ready, 1'b0);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(mk(32'(idx) | (32'(idx) << 16), 1'b0, 1'b0, idx == 0));
                idx++;
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        drain();

        // Reset with beats in flight: none may come out
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.a = 32'd10; bus.b = 32'd20; bus.sub = 1'b0; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.a = 32'd30;
        @(posedge clk); #1;
        bus.a = 32'd40;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check1("rst_flush_valid", bus.out_valid, 1'b0);
        end
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0));
        idle();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check1("latency_valid", bus.out_valid, j == 3);
        end
        drain();

`ifdef ADDSUB_SAT_EN
        // Saturating beats clamp, non-saturating beats wrap
        sat_sel = 1'b1;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0));
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1, 1'b0));
        sat_sel = 1'b0;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        idle();
        drain();
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
